// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - Op encodings as driven on the Op port by the decoder.
//   - FSM state encodings used by mult_div_unit.
//   - Iteration count and a couple of op-decode helpers.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH      = 32;
  localparam int unsigned MDU_ITERATIONS = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ITER = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } mdu_step_mode_e;

  // Op[1] selects divide, Op[0] selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   acc       in   2*WIDTH+1  accumulator {upper(WIDTH+1), lower(WIDTH)}
//   operand   in   WIDTH      multiplicand magnitude / divisor magnitude
//   mode      in   1          STEP_MUL (shift-add) or STEP_DIV (restoring)
//   acc_next  out  2*WIDTH+1  accumulator after this step
//   q_bit     out  1          quotient bit produced by a divide step (0 for multiply)
// Multiply: lower holds the not-yet-consumed multiplier bits; the product ends up in
// acc[2*WIDTH-1:0]. Divide: lower starts as the dividend and is shifted out MSB first;
// the freed LSB is left at 0 and the caller inserts q_bit there.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  mdu_step_mode_e   mode,
  output logic [2*WIDTH:0] acc_next,
  output logic             q_bit
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  always_comb begin
    upper    = acc[2*WIDTH:WIDTH];
    sum      = '0;
    shifted  = '0;
    trial    = '0;
    borrow   = 1'b0;
    q_bit    = 1'b0;
    acc_next = acc;
    if (mode == STEP_MUL) begin
      // upper < 2^WIDTH before the add, so the sum always fits in WIDTH+1 bits
      sum      = acc[0] ? (upper + {1'b0, operand}) : upper;
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end else begin
      shifted           = {upper[WIDTH-1:0], acc[WIDTH-1]};
      {borrow, trial}   = {1'b0, shifted} - {2'b00, operand};
      q_bit             = ~borrow;
      // restore on borrow: keep the shifted partial remainder
      acc_next          = {(borrow ? shifted : trial), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Ports:
//   CLK          in   1      clock, posedge
//   RESET        in   1      asynchronous active-high reset
//   Start        in   1      launch the op on Op; sampled only in IDLE
//   Op           in   2      MDU_MULT / MDU_MULTU / MDU_DIV / MDU_DIVU
//   Operand_A    in   WIDTH  rs: multiplicand / dividend, MTHI/MTLO source
//   Operand_B    in   WIDTH  rt: multiplier / divisor
//   HI_Write     in   1      MTHI, honoured only in IDLE when Start is low
//   LO_Write     in   1      MTLO, honoured only in IDLE when Start is low
//   Busy         out  1      op in flight
//   Done         out  1      one-cycle pulse, HI/LO already final
//   Div_By_Zero  out  1      one-cycle pulse with Done for a zero divisor
//   HI, LO       out  WIDTH  architectural HI/LO registers
// Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             HI_Write,
  input  logic             LO_Write,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_pulse_q, dbz_pulse_d;

  logic             is_div, is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] quot, rem;
  mdu_step_mode_e   step_mode;
  logic [2*WIDTH:0] step_acc;
  logic             step_qbit;

  // Operand magnitudes, step mode and sign-corrected results.
  always_comb begin
    is_div    = op_is_div(op_q);
    is_signed = op_is_signed(op_q);
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    a_mag     = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag     = b_neg ? (~b_q + 1'b1) : b_q;
    step_mode = is_div ? STEP_DIV : STEP_MUL;
    product   = neg_lo_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
    quot      = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem       = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .mode     (step_mode),
    .acc_next (step_acc),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    dbz_d       = dbz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          // a move issued together with Start is dropped
          op_d    = Op;
          a_d     = Operand_A;
          b_d     = Operand_B;
          state_d = S_PREP;
        end else begin
          if (HI_Write) hi_d = Operand_A;
          if (LO_Write) lo_d = Operand_A;
        end
      end
      S_PREP: begin
        dbz_d = is_div && (b_q == '0);
        if (is_div && (b_q == '0)) begin
          // routed through FIX so the abort is reported on the same edge spacing
          // as a normal completion, without touching HI/LO
          state_d = S_FIX;
        end else begin
          opnd_d   = is_div ? b_mag : a_mag;
          acc_d    = {{(WIDTH+1){1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_d    = '0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = is_div ? a_neg : (a_neg ^ b_neg);
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        acc_d = {step_acc[2*WIDTH:1], (is_div ? step_qbit : step_acc[0])};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dbz_q) begin
          dbz_pulse_d = 1'b1;
        end else if (is_div) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      dbz_q       <= dbz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      dbz_pulse_q <= dbz_pulse_d;
    end
  end

  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign Div_By_Zero = dbz_pulse_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule
